// File: rtl/div_datapath_pkg.sv
// Shared constants, command codes and decoded-op enum for the divider datapath.
// Contents: DIV_W, SUBU_* ALU command codes, div_op_e.
package div_pkg;

  localparam int DIV_W = 32;

  localparam logic [5:0] SUBU_NOP = 6'b000000;
  localparam logic [5:0] SUBU_ADD = 6'b000001;
  localparam logic [5:0] SUBU_SUB = 6'b000010;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_LOAD,
    OP_SRL,
    OP_SLL,
    OP_W,
    OP_SUB,
    OP_ADD
  } div_op_e;

endpackage

// File: rtl/div_datapath_if.sv
// Command/operand/result bundle between divider control FSM and datapath.
// master: FSM side (drives commands, operands); slave: datapath side.
interface div_datapath_if;
  import div_pkg::*;

  logic [DIV_W-1:0] Dividend;
  logic [DIV_W-1:0] Divisor;
  logic [5:0]       Subu_ctrl;
  logic             W_ctrl;
  logic             SLL_ctrl;
  logic             SRL_ctrl;
  logic             Neg_Rem;
  logic [DIV_W-1:0] Quotient;
  logic [DIV_W-1:0] Remainder;

  modport master (
    output Dividend, Divisor,
    output Subu_ctrl, W_ctrl,
    output SLL_ctrl, SRL_ctrl,
    input  Neg_Rem, Quotient, Remainder
  );

  modport slave (
    input  Dividend, Divisor,
    input  Subu_ctrl, W_ctrl,
    input  SLL_ctrl, SRL_ctrl,
    output Neg_Rem, Quotient, Remainder
  );

endinterface

// File: rtl/div_datapath_alu.sv
// Combinational 33-bit ALU: h - d, a + d, and unsigned h < d.
// Ports: h, a (33b), d (WIDTH), diff, sum (33b), lt.
module div_alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   h,
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   diff,
  output logic [WIDTH:0]   sum,
  output logic             lt
);

  logic [WIDTH:0] dx;

  assign dx   = {1'b0, d};
  assign diff = h - dx;
  assign sum  = a + dx;
  assign lt   = h < dx;

endmodule

// File: rtl/div_datapath.sv
// Restoring-division datapath: remainder/quotient shift register, divisor, ALU.
// Ports: clk, Reset (sync, active-high), bus (slave: commands in, results out).
module div_datapath
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input logic           clk,
  input logic           Reset,
  div_datapath_if.slave bus
);

  logic [2*WIDTH:0] r;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   a;
  logic             neg;
  logic             a_pend;
  logic             sub_seen;

  logic [WIDTH:0]   h;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   sum;
  logic             lt;
  div_op_e          op;

  assign h = r[2*WIDTH:WIDTH];

  div_alu #(.WIDTH(WIDTH)) u_alu (
    .h    (h),
    .a    (a),
    .d    (d),
    .diff (diff),
    .sum  (sum),
    .lt   (lt)
  );

  // Several pulses may coincide; only the
  // highest-priority one runs, the rest drop.
  always_comb begin
    op = OP_NONE;
    priority case (1'b1)
      Reset:        op = OP_LOAD;
      bus.SRL_ctrl: op = OP_SRL;
      bus.SLL_ctrl: op = OP_SLL;
      bus.W_ctrl:   op = OP_W;
      (bus.Subu_ctrl == SUBU_SUB):
                    op = OP_SUB;
      (bus.Subu_ctrl == SUBU_ADD):
                    op = OP_ADD;
      default:      op = OP_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    unique case (op)
      OP_LOAD: begin
        r        <= {{(WIDTH+1){1'b0}}, bus.Dividend};
        d        <= bus.Divisor;
        a        <= '0;
        neg      <= 1'b0;
        a_pend   <= 1'b0;
        sub_seen <= 1'b0;
      end
      OP_SRL: r[2*WIDTH:WIDTH] <= {1'b0, h[WIDTH:1]};
      // Quotient bit is 0 until a SUB has
      // been seen (first shift after load).
      OP_SLL: r <= {r[2*WIDTH-1:0], sub_seen & ~neg};
      OP_W: begin
        if (a_pend) begin
          r[2*WIDTH:WIDTH] <= a;
          a_pend           <= 1'b0;
        end
      end
      OP_SUB: begin
        a        <= diff;
        neg      <= lt;
        a_pend   <= 1'b1;
        sub_seen <= 1'b1;
      end
      OP_ADD: begin
        a      <= sum;
        a_pend <= 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.Neg_Rem   = neg;
  assign bus.Quotient  = r[WIDTH-1:0];
  assign bus.Remainder = r[2*WIDTH-1:WIDTH];

endmodule
